// File: rtl/function_unit_mc.sv
// Execute stage: single-cycle ALU/shift ops plus a 16-step shift-add multiplier.
// Results, write-back address and status flags are registered per completed op.
module function_unit_mc #(
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       FS,
    input  logic [AW-1:0]    DA_in,
    input  logic             start,
    output logic [WIDTH-1:0] D,
    output logic [AW-1:0]    DA,
    output logic             RW,
    output logic             busy,
    output logic             done,
    output logic             V,
    output logic             C,
    output logic             N,
    output logic             Z
);
    typedef enum logic {IDLE, MUL} state_t;

    localparam logic [3:0]       FS_MUL = 4'hB;
    localparam logic [WIDTH-1:0] ONE    = WIDTH'(1);
    localparam int               MSB    = WIDTH - 1;

    state_t             state_q, state_d;
    logic [4:0]         cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [AW-1:0]      pend_da_q, pend_da_d;
    logic [WIDTH-1:0]   d_q, d_d;
    logic [AW-1:0]      da_q, da_d;
    logic               rw_q, rw_d, busy_q, busy_d, done_q, done_d;
    logic               v_q, v_d, c_q, c_d, n_q, n_d, z_q, z_d;

    logic [WIDTH-1:0]   res;
    logic [WIDTH:0]     ext;
    logic               res_c, res_v;

    // Single-cycle operation result and its carry/overflow
    always_comb begin
        res   = '0;
        ext   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        case (FS)
            4'h0: res = A;
            4'h1: begin
                ext   = {1'b0, A} + {1'b0, ONE};
                res   = ext[WIDTH-1:0];
                res_c = ext[WIDTH];
                res_v = ~A[MSB] & res[MSB];
            end
            4'h2: begin
                ext   = {1'b0, A} + {1'b0, B};
                res   = ext[WIDTH-1:0];
                res_c = ext[WIDTH];
                res_v = (A[MSB] == B[MSB]) && (res[MSB] != A[MSB]);
            end
            4'h3: begin
                ext   = {1'b0, A} - {1'b0, B};
                res   = ext[WIDTH-1:0];
                res_c = ~ext[WIDTH];
                res_v = (A[MSB] != B[MSB]) && (res[MSB] != A[MSB]);
            end
            4'h4: begin
                ext   = {1'b0, A} - {1'b0, ONE};
                res   = ext[WIDTH-1:0];
                res_c = ~ext[WIDTH];
                res_v = A[MSB] & ~res[MSB];
            end
            4'h5: res = A & B;
            4'h6: res = A | B;
            4'h7: res = A ^ B;
            4'h8: res = ~A;
            4'h9: begin
                res   = {1'b0, B[WIDTH-1:1]};
                res_c = B[0];
            end
            4'hA: begin
                res   = {B[WIDTH-2:0], 1'b0};
                res_c = B[MSB];
            end
            4'hC: res = B;
            default: res = '0;
        endcase
    end

    assign acc_step = mplier_q[0] ? acc_q + mcand_q : acc_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        pend_da_d = pend_da_q;
        d_d       = d_q;
        da_d      = da_q;
        busy_d    = busy_q;
        v_d       = v_q;
        c_d       = c_q;
        n_d       = n_q;
        z_d       = z_q;
        rw_d      = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (FS == FS_MUL) begin
                        state_d   = MUL;
                        busy_d    = 1'b1;
                        cnt_d     = '0;
                        acc_d     = '0;
                        mcand_d   = {{WIDTH{1'b0}}, A};
                        mplier_d  = B;
                        pend_da_d = DA_in;
                    end else if (FS > 4'hC) begin
                        done_d = 1'b1;
                    end else begin
                        d_d    = res;
                        da_d   = DA_in;
                        v_d    = res_v;
                        c_d    = res_c;
                        n_d    = res[MSB];
                        z_d    = (res == '0);
                        rw_d   = 1'b1;
                        done_d = 1'b1;
                    end
                end
            end
            MUL: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    d_d     = acc_step[WIDTH-1:0];
                    da_d    = pend_da_q;
                    v_d     = 1'b0;
                    c_d     = (acc_step[2*WIDTH-1:WIDTH] != '0);
                    n_d     = acc_step[MSB];
                    z_d     = (acc_step[WIDTH-1:0] == '0);
                    rw_d    = 1'b1;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            pend_da_q <= '0;
            d_q       <= '0;
            da_q      <= '0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            v_q       <= 1'b0;
            c_q       <= 1'b0;
            n_q       <= 1'b0;
            z_q       <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            pend_da_q <= pend_da_d;
            d_q       <= d_d;
            da_q      <= da_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            v_q       <= v_d;
            c_q       <= c_d;
            n_q       <= n_d;
            z_q       <= z_d;
        end
    end

    assign D    = d_q;
    assign DA   = da_q;
    assign RW   = rw_q;
    assign busy = busy_q;
    assign done = done_q;
    assign V    = v_q;
    assign C    = c_q;
    assign N    = n_q;
    assign Z    = z_q;
endmodule
